priority_arbiter: RTL and testbench

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter_if.sv | 28 ++
 rtl/priority_arbiter.sv | 104 ++++++++++
 tb/tb_priority_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between a set of requesters and the priority arbiter.
// The arbiter connects to the slave modport; the requester side uses master.
interface priority_arbiter_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic         ack;
    logic [W-1:0] idx;
    logic [N-1:0] grant;
    logic         valid;

    modport master (
        output req,
        output ack,
        input  idx,
        input  grant,
        input  valid
    );

    modport slave (
        input  req,
        input  ack,
        output idx,
        output grant,
        output valid
    );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter with fixed-priority or round-robin selection.
// A grant is held until acknowledged, followed by one idle bubble cycle.
module priority_arbiter #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_arbiter_if.slave    bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] grant_q, grant_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] winner;

    // Fixed mode: highest set bit wins. Round-robin: search ptr downward, wrapping.
    always_comb begin
        logic found;
        int   cand;
        logic [W-1:0] pos;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        pos    = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                pos = W'(i);
                if (bus.req[pos]) winner = pos;
            end
        end else begin
            for (int off = 0; off < N; off++) begin
                cand = int'(ptr_q) - off;
                if (cand < 0) cand = cand + N;
                pos = W'(cand);
                if (!found && bus.req[pos]) begin
                    winner = pos;
                    found  = 1'b1;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                idx_d   = '0;
                grant_d = '0;
                valid_d = 1'b0;
                if (|bus.req) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    grant_d = N'(1) << winner;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (bus.ack) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    grant_d = '0;
                    valid_d = 1'b0;
                    if (MODE == 1) ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.idx   = idx_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: one fixed-priority and one round-robin
// instance, both N = 8, driven from a single stimulus sequence.
module tb_priority_arbiter;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    priority_arbiter_if #(.N(N)) bus_fix ();
    priority_arbiter_if #(.N(N)) bus_rr ();

    priority_arbiter #(.N(N), .MODE(0)) dut_fix (.clk(clk), .rst(rst), .bus(bus_fix));
    priority_arbiter #(.N(N), .MODE(1)) dut_rr  (.clk(clk), .rst(rst), .bus(bus_rr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fix(input string tag, input logic v, input int i);
        check({tag, ".valid"}, 32'(bus_fix.valid), 32'(v));
        check({tag, ".idx"},   32'(bus_fix.idx),   32'(v ? i : 0));
        check({tag, ".grant"}, 32'(bus_fix.grant), v ? (32'd1 << i) : 32'd0);
    endtask

    task automatic check_rr(input string tag, input logic v, input int i);
        check({tag, ".valid"}, 32'(bus_rr.valid), 32'(v));
        check({tag, ".idx"},   32'(bus_rr.idx),   32'(v ? i : 0));
        check({tag, ".grant"}, 32'(bus_rr.grant), v ? (32'd1 << i) : 32'd0);
    endtask

    int rot_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    initial begin
        rst = 1'b1;
        bus_fix.req = '0; bus_fix.ack = 1'b0;
        bus_rr.req  = '0; bus_rr.ack  = 1'b0;
        step();
        step();
        check_fix("reset_fix", 1'b0, 0);
        check_rr("reset_rr", 1'b0, 0);
        check("reset_ptr_rr", 32'(dut_rr.ptr_q), 32'd7);
        rst = 1'b0;

        // Idle with no requests, then ack while idle
        step();
        check_fix("idle_noreq", 1'b0, 0);
        bus_fix.ack = 1'b1;
        step();
        check_fix("idle_ack", 1'b0, 0);
        bus_fix.ack = 1'b0;

        // Fixed priority selection
        bus_fix.req = 8'b0010_0110;
        step();
        check_fix("fix_sel", 1'b1, 5);

        // Hold with requests dropped
        bus_fix.req = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_fix("fix_hold", 1'b1, 5);
        end

        // Ack, bubble, next grant
        bus_fix.ack = 1'b1;
        bus_fix.req = 8'b0000_0011;
        step();
        check_fix("fix_bubble", 1'b0, 0);
        bus_fix.ack = 1'b0;
        step();
        check_fix("fix_next", 1'b1, 1);
        bus_fix.ack = 1'b1;
        bus_fix.req = '0;
        step();
        check_fix("fix_release", 1'b0, 0);
        bus_fix.ack = 1'b0;
        check("fix_ptr_const", 32'(dut_fix.ptr_q), 32'd7);

        // Round-robin rotation with all requests held
        bus_rr.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_rr($sformatf("rr_rot%0d", k), 1'b1, rot_seq[k]);
            bus_rr.ack = 1'b1;
            step();
            check_rr($sformatf("rr_gap%0d", k), 1'b0, 0);
            bus_rr.ack = 1'b0;
        end

        // Wrap: grant 1 acked, then 0 wins, then 7 wins
        bus_rr.req = 8'b0000_0010;
        step();
        check_rr("rr_one", 1'b1, 1);
        bus_rr.ack = 1'b1;
        step();
        bus_rr.ack = 1'b0;
        check("rr_ptr_after1", 32'(dut_rr.ptr_q), 32'd0);
        bus_rr.req = 8'b1000_0001;
        step();
        check_rr("rr_wrap0", 1'b1, 0);
        bus_rr.ack = 1'b1;
        step();
        bus_rr.ack = 1'b0;
        step();
        check_rr("rr_wrap7", 1'b1, 7);

        // Hold in round-robin while req changes
        bus_rr.req = 8'b0000_0001;
        step();
        check_rr("rr_hold", 1'b1, 7);
        bus_rr.ack = 1'b1;
        step();
        bus_rr.ack = 1'b0;

        // Reset mid-grant at idx 3, with ack low
        bus_rr.req = 8'b0000_1000;
        step();
        check_rr("rr_idx3", 1'b1, 3);
        rst = 1'b1;
        step();
        check_rr("rr_rst_mid", 1'b0, 0);
        check("rr_rst_ptr", 32'(dut_rr.ptr_q), 32'd7);
        rst = 1'b0;
        bus_rr.req = 8'hFF;
        step();
        check_rr("rr_after_rst", 1'b1, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
